// File: rtl/la_prbs.sv
// la_prbs: XNOR-feedback Fibonacci PRBS generator plus a self-synchronising checker.
//   clk, nreset          clock and synchronous active-low reset
//   gen_en, gen_load     advance the generator / load gen_seed (load wins)
//   gen_seed [N]         generator seed; all-ones is replaced by all-zeros
//   gen_bit              generator output, straight from the MSB of the state
//   chk_valid, chk_bit   received stream bit and its qualifier
//   chk_clr              clear the error counter
//   locked, err          checker lock state and per-mismatch pulse
//   err_count [CW]       saturating mismatch count
module la_prbs #(
  parameter int N = 7,
  parameter int CW = 16,
  parameter int LOSS = 4,
  parameter string PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          gen_en,
  input  logic          gen_load,
  input  logic [N-1:0]  gen_seed,
  output logic          gen_bit,
  input  logic          chk_valid,
  input  logic          chk_bit,
  input  logic          chk_clr,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_count
);
  localparam int T1 = N;
  localparam int T2 = N == 7 ? 6 : N == 15 ? 14 : N == 23 ? 18 : 28;
  localparam int FW = $clog2(N);
  if (!(N == 7 || N == 15 || N == 23 || N == 31) || LOSS < 1 || LOSS > 15) begin : g_bad_param
    $error("la_prbs: unsupported N or LOSS");
  end
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state;
  logic [N-1:0] s, r, r_sh;
  logic [FW-1:0] fill;
  logic [3:0] miss;
  logic p, hit;
  // In LOCKED the checker free-runs on its own prediction, so a flipped input
  // bit never pollutes the shift register and costs exactly one error.
  always_comb begin
    p = ~(r[T1-1] ^ r[T2-1]);
    r_sh = {r[N-2:0], state == LOCKED ? p : chk_bit};
    hit = chk_valid && state == LOCKED && chk_bit != p;
  end
  assign gen_bit = s[N-1];
  assign locked = state == LOCKED;
  always_ff @(posedge clk) begin
    if (!nreset) begin
      s <= '0;
      r <= '0;
      fill <= '0;
      miss <= '0;
      state <= SEARCH;
      err <= 1'b0;
      err_count <= '0;
    end else begin
      if (gen_load) s <= &gen_seed ? '0 : gen_seed;
      else if (gen_en) s <= {s[N-2:0], ~(s[T1-1] ^ s[T2-1])};
      err <= hit;
      if (chk_clr) err_count <= CW'(hit);
      else if (hit && !(&err_count)) err_count <= err_count + CW'(1);
      if (chk_valid) begin
        r <= r_sh;
        if (state == SEARCH) begin
          fill <= fill == FW'(N-1) ? '0 : fill + FW'(1);
          // An all-ones window means a stuck-at-1 line: refill instead of locking.
          if (fill == FW'(N-1) && !(&r_sh)) begin
            state <= LOCKED;
            miss <= '0;
          end
        end else if (hit && miss == 4'(LOSS-1)) begin
          state <= SEARCH;
          fill <= '0;
          miss <= '0;
        end else begin
          miss <= hit ? miss + 4'd1 : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_la_prbs.sv
// tb_la_prbs: randomized self-checking bench for la_prbs against a queue-based stream model.
module tb_la_prbs;
  localparam int N = 7, CW = 4, LOSS = 4, T1 = 7, T2 = 6;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, nreset = 0, gen_en = 0, gen_load = 0;
  logic chk_valid = 0, chk_bit = 0, chk_clr = 0;
  logic [N-1:0] gen_seed = '0;
  logic gen_bit, locked, err;
  logic [CW-1:0] err_count;
  la_prbs #(.N(N), .CW(CW), .LOSS(LOSS)) dut (
    .clk(clk), .nreset(nreset), .gen_en(gen_en), .gen_load(gen_load),
    .gen_seed(gen_seed), .gen_bit(gen_bit), .chk_valid(chk_valid),
    .chk_bit(chk_bit), .chk_clr(chk_clr), .locked(locked), .err(err),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  bit gq[$], rq[$];
  bit mlock, merr;
  int fill, miss, cnt;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit all_ones(input bit q[$]);
    foreach (q[i]) if (!q[i]) return 0;
    return 1;
  endfunction
  // src: 0 = constant 0, 1 = constant 1, 2 = loopback, 3 = inverted loopback
  task automatic cyc(input bit nr, input bit ge, input bit gl, input logic [N-1:0] seed,
                     input bit cv, input int src, input bit cc);
    bit cb, p, hit, fb;
    cb = src == 0 ? 1'b0 : src == 1 ? 1'b1 : src == 2 ? gq[0] : !gq[0];
    nreset = nr; gen_en = ge; gen_load = gl; gen_seed = seed;
    chk_valid = cv; chk_bit = cb; chk_clr = cc;
    @(posedge clk); #1;
    hit = 0;
    if (!nr) begin
      gq = {}; rq = {};
      for (int i = 0; i < N; i++) begin gq.push_back(0); rq.push_back(0); end
      mlock = 0; fill = 0; miss = 0; cnt = 0;
    end else begin
      if (gl) begin
        gq = {};
        for (int i = 0; i < N; i++) gq.push_back(seed == '1 ? 1'b0 : seed[N-1-i]);
      end else if (ge) begin
        fb = !(gq[N-T1] ^ gq[N-T2]);
        gq.push_back(fb); void'(gq.pop_front());
      end
      if (cv) begin
        if (!mlock) begin
          rq.push_back(cb); void'(rq.pop_front());
          fill++;
          if (fill == N) begin
            fill = 0;
            if (!all_ones(rq)) begin mlock = 1; miss = 0; end
          end
        end else begin
          p = !(rq[N-T1] ^ rq[N-T2]);
          rq.push_back(p); void'(rq.pop_front());
          if (cb != p) begin
            hit = 1; miss++;
            if (miss == LOSS) begin mlock = 0; fill = 0; miss = 0; end
          end else miss = 0;
        end
      end
      cnt = cc ? int'(hit) : (hit && cnt < SAT) ? cnt + 1 : cnt;
    end
    merr = hit;
    check("gen_bit", gen_bit, gq[0]);
    check("locked", locked, mlock);
    check("err", err, merr);
    check("err_count", err_count, cnt);
  endtask
  task automatic run(input int n, input int src);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, '0, 1, src, 0);
  endtask
  initial begin
    logic [8:0] seq;
    logic [N-1:0] sd;
    int n, k;
    seq = 9'h180;
    cyc(0, 1, 1, 7'h55, 1, 1, 1);
    cyc(0, 1, 0, '0, 1, 3, 0);
    check("rst_gen_bit", gen_bit, 0);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);
    for (int i = 1; i <= 135; i++) begin
      cyc(1, 1, 0, '0, 0, 0, 0);
      if (i <= 8) check("seq", gen_bit, seq[i]);
      if (i >= 127) check("period", gen_bit, seq[i-127]);
    end
    cyc(0, 0, 0, '0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 1, 0, '0, 1, 2, 0);
      check("lock_at_n", locked, i == 7);
    end
    run(1000, 2);
    check("loop_errs", err_count, 0);
    check("loop_locked", locked, 1);
    run($urandom_range(1, 20), 2);
    cyc(1, 1, 0, '0, 1, 3, 0);
    check("single_err", err, 1);
    run(10, 2);
    check("single_cnt", err_count, 1);
    check("single_locked", locked, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0, 1, 3, 0);
    run(5, 2);
    check("triple_cnt", err_count, 4);
    check("triple_locked", locked, 1);
    cyc(1, 1, 0, '0, 1, 2, 1);
    check("clr", err_count, 0);
    cyc(1, 1, 0, '0, 1, 3, 1);
    check("clr_hit", err_count, 1);
    run(3, 2);
    k = 0;
    while (locked && k < 200) begin cyc(1, 1, 0, '0, 1, 0, 0); k++; end
    check("loss", locked, 0);
    n = 0; k = 0;
    while (n < 7 && k < 100) begin
      bit v;
      v = $urandom_range(0, 1);
      cyc(1, v, 0, '0, v, 2, 0);
      n += int'(v); k++;
      check("relock", locked, n >= 7);
    end
    for (int i = 0; i < 200; i++) begin
      bit v;
      v = $urandom_range(0, 3) != 0;
      cyc(1, v, 0, '0, v, $urandom_range(0, 49) == 0 ? 3 : 2, 0);
    end
    cyc(0, 0, 0, '0, 0, 0, 0);
    run(300, 3);
    check("sat", err_count, SAT);
    cyc(0, 0, 0, '0, 0, 0, 0);
    run(60, 1);
    check("stuck1", locked, 0);
    run($urandom_range(3, 40), 2);
    cyc(1, 0, 1, '1, 0, 0, 0);
    check("seed_ones", gen_bit, 0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 1, 0, '0, 0, 0, 0);
      check("seed_ones_seq", gen_bit, i == 7);
    end
    cyc(1, 0, 1, '0, 0, 0, 0);
    cyc(1, 1, 1, 7'h40, 0, 0, 0);
    check("load_wins", gen_bit, 1);
    for (int i = 0; i < 10; i++) begin
      sd = N'($urandom);
      if (i == 0) sd = '1;
      cyc(1, 1, 1, sd, 0, 0, 0);
      check("seed_rand", gen_bit, sd == '1 ? 1'b0 : sd[N-1]);
      run($urandom_range(1, 10), 2);
    end
    cyc(0, 0, 0, '0, 0, 0, 0);
    run(10, 2);
    cyc(1, 1, 0, '0, 1, 3, 0);
    run(3, 2);
    check("pre_rst_locked", locked, 1);
    cyc(0, 1, 1, 7'h55, 1, 3, 0);
    check("rst_lk_gen_bit", gen_bit, 0);
    check("rst_lk_locked", locked, 0);
    check("rst_lk_err", err, 0);
    check("rst_lk_err_count", err_count, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
